// File: rtl/tick_timer_sched.sv
`default_nettype none
// ============================================================================
// Module   : tick_timer_sched
// Brief    : One shared prescaler tick drives NUM_CH one-shot down-counters;
//            expiries leave through a single round-robin valid/ready port.
//            Optional macro TICK_SYNC_START_EN holds the prescaler while idle.
// Revision : 1.0  initial release
// ============================================================================
module tick_timer_sched #(
    parameter int NUM_CH   = 4,
    parameter int PRESCALE = 1999,
    parameter int CNT_W    = 16
) (
    input  logic                        iClk,
    input  logic                        iRst_n,
    input  logic [NUM_CH-1:0]           iStart,
    input  logic [NUM_CH-1:0]           iStop,
    input  logic [NUM_CH*CNT_W-1:0]     iDelay,
    output logic [NUM_CH-1:0]           oBusy,
    output logic                        oTick,
    output logic                        oDoneVld,
    output logic [$clog2(NUM_CH)-1:0]   oDoneCh,
    input  logic                        iDoneRdy
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PRE_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_PEND = 2'd2;

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              tick_q, tick_d;
    logic              w_tick;

    logic              done_vld_q, done_vld_d;
    logic [CH_W-1:0]   done_ch_q, done_ch_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic              w_hs;
    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_ack;
    logic [NUM_CH-1:0] w_cand;
    logic              w_found;
    logic [CH_W-1:0]   w_win;
    logic [CH_W-1:0]   w_idx;

    // ------------------------------------------------------------------------
    // Shared prescaler
    // ------------------------------------------------------------------------
    assign w_tick = (pre_q == PRE_W'(PRESCALE));

`ifdef TICK_SYNC_START_EN
    logic w_all_idle;
    assign w_all_idle = ~|oBusy;
`endif

    always_comb begin
        pre_d  = w_tick ? '0 : pre_q + PRE_W'(1);
`ifdef TICK_SYNC_START_EN
        // Phase-align the tick to the first start so the first expiry is exact
        if (w_all_idle) pre_d = '0;
`endif
        tick_d = w_tick;
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    assign oTick = tick_q;

    // ------------------------------------------------------------------------
    // Per-channel one-shot timers
    // ------------------------------------------------------------------------
    assign w_hs = done_vld_q & iDoneRdy;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [1:0]       st_q, st_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] w_dly;

        assign w_dly    = iDelay[n*CNT_W +: CNT_W];
        assign w_ack[n] = w_hs && (done_ch_q == CH_W'(n));

        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            case (st_q)
                c_IDLE: begin
                    if (iStart[n] && !iStop[n]) begin
                        if (w_dly != '0) begin
                            st_d  = c_RUN;
                            cnt_d = w_dly;
                        end else begin
                            st_d  = c_PEND;
                        end
                    end
                end
                c_RUN: begin
                    // Stop beats retrigger, retrigger beats the tick
                    if (iStop[n]) begin
                        st_d = c_IDLE;
                    end else if (iStart[n]) begin
                        if (w_dly != '0) begin
                            cnt_d = w_dly;
                        end else begin
                            st_d  = c_PEND;
                        end
                    end else if (w_tick) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            st_d  = c_PEND;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                c_PEND: begin
                    if (w_ack[n]) st_d = c_IDLE;
                end
                default: st_d = c_IDLE;
            endcase
        end

        always_ff @(posedge iClk) begin
            if (!iRst_n) begin
                st_q  <= c_IDLE;
                cnt_q <= '0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
            end
        end

        assign w_pend[n] = (st_q == c_PEND);
        assign oBusy[n]  = (st_q != c_IDLE);
    end

    // ------------------------------------------------------------------------
    // Round-robin expiry arbiter
    // ------------------------------------------------------------------------
    always_comb begin
        // The channel acknowledged this cycle is leaving PEND; skip it
        w_cand  = w_pend & ~w_ack;
        w_found = 1'b0;
        w_win   = ptr_q;
        w_idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = CH_W'((int'(ptr_q) + i) % NUM_CH);
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        done_vld_d = done_vld_q;
        done_ch_d  = done_ch_q;
        ptr_d      = ptr_q;
        if (!done_vld_q || w_hs) begin
            done_vld_d = w_found;
            if (w_found) begin
                done_ch_d = w_win;
                ptr_d     = w_win;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            done_vld_q <= 1'b0;
            done_ch_q  <= '0;
            ptr_q      <= CH_W'(NUM_CH - 1);
        end else begin
            done_vld_q <= done_vld_d;
            done_ch_q  <= done_ch_d;
            ptr_q      <= ptr_d;
        end
    end

    assign oDoneVld = done_vld_q;
    assign oDoneCh  = done_ch_q;

endmodule
`default_nettype wire
